// File: rtl/mod_select_pkg.sv
// Shared types for the sequential modulo-compare-select block.
package mod_select_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    SEL,
    HOLD
  } state_t;

  // Width of a counter able to hold values 0..w
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mod_select_seq_if.sv
// Operand/result handshake bundle for mod_select_seq.
interface mod_select_seq_if #(
  parameter int unsigned DATAWIDTH = 64
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] c;
  logic [DATAWIDTH-1:0] zero;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] z;
  logic [DATAWIDTH-1:0] g;
  logic                 eq;
  logic                 div0;

  modport master (
    output in_valid, a, c, zero, out_ready,
    input  in_ready, out_valid, z, g, eq, div0
  );

  modport slave (
    input  in_valid, a, c, zero, out_ready,
    output in_ready, out_valid, z, g, eq, div0
  );
endinterface

// File: rtl/mod_select_seq_iter.sv
// Iterative restoring remainder unit: one dividend bit per cycle, MSB first.
module mod_iter
  import mod_select_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] dividend,
  input  logic [DATAWIDTH-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] rem
);
  localparam int unsigned CW = cnt_width(DATAWIDTH);
  localparam int unsigned IW = $clog2(DATAWIDTH);

  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATAWIDTH:0]   trial;
  logic [DATAWIDTH-1:0] diff;
  logic                 ge;

  // trial carries one extra bit so the compare against the divisor never overflows
  always_comb begin
    idx   = IW'(DATAWIDTH - 1) - cnt[IW-1:0];
    trial = {rem, dividend[idx]};
    ge    = (trial >= {1'b0, divisor});
    diff  = trial[DATAWIDTH-1:0] - divisor;
    done  = busy && (cnt == CW'(DATAWIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      rem  <= '0;
    end else if (busy) begin
      rem <= ge ? diff : trial[DATAWIDTH-1:0];
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/mod_select_seq.sv
// Sequential z = (a % c == zero) ? a - 1 : c + 1 with valid/ready on both sides.
module mod_select_seq
  import mod_select_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 64
) (
  input logic             clk,
  input logic             rst,
  mod_select_seq_if.slave bus
);
  state_t               state, state_nxt;
  logic                 accept;
  logic                 iter_busy, iter_done;
  logic [DATAWIDTH-1:0] a_q, c_q, zero_q, rem;
  logic                 hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) begin
        accept    = 1'b1;
        state_nxt = DIV;
      end
      DIV:  if (iter_done || !iter_busy) state_nxt = SEL;
      SEL:  state_nxt = HOLD;
      HOLD: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      c_q    <= '0;
      zero_q <= '0;
    end else if (accept) begin
      a_q    <= bus.a;
      c_q    <= bus.c;
      zero_q <= bus.zero;
    end
  end

  mod_iter #(.DATAWIDTH(DATAWIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .dividend (a_q),
    .divisor  (c_q),
    .busy     (iter_busy),
    .done     (iter_done),
    .rem      (rem)
  );

  assign hit = (rem == zero_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.z         <= '0;
      bus.g         <= '0;
      bus.eq        <= 1'b0;
      bus.div0      <= 1'b0;
    end else if (state == SEL) begin
      bus.out_valid <= 1'b1;
      bus.g         <= rem;
      bus.eq        <= hit;
      bus.z         <= hit ? a_q - 1'b1 : c_q + 1'b1;
      bus.div0      <= (c_q == '0);
    end else if (state == HOLD && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mod_select_seq.sv
// Directed bench for mod_select_seq at DATAWIDTH 8 and 64.
module tb_mod_select_seq;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mod_select_seq_if #(.DATAWIDTH(8))  bus8 ();
  mod_select_seq_if #(.DATAWIDTH(64)) bus64 ();

  mod_select_seq #(.DATAWIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  mod_select_seq #(.DATAWIDTH(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

  typedef struct {
    logic [7:0] a, c, zero;
    logic [7:0] g, z;
    logic       eq, div0;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Starts in IDLE just after an edge; returns with out_valid high (or bound expired).
  task automatic run8(input vec_t v);
    int lat;
    bus8.a = v.a; bus8.c = v.c; bus8.zero = v.zero; bus8.in_valid = 1'b1;
    chk("in_ready_before_accept", 64'(bus8.in_ready), 64'd1);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    bus8.a = ~v.a; bus8.c = ~v.c; bus8.zero = ~v.zero;
    lat = 0;
    while (!bus8.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency8", 64'(lat), 64'd9);
    chk("g", 64'(bus8.g), 64'(v.g));
    chk("z", 64'(bus8.z), 64'(v.z));
    chk("eq", 64'(bus8.eq), 64'(v.eq));
    chk("div0", 64'(bus8.div0), 64'(v.div0));
    chk("in_ready_busy", 64'(bus8.in_ready), 64'd0);
  endtask

  task automatic ack8();
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    chk("out_valid_after_ack", 64'(bus8.out_valid), 64'd0);
    chk("in_ready_after_ack", 64'(bus8.in_ready), 64'd1);
  endtask

  initial begin
    int   lat;
    vec_t v;

    tbl[0] = '{a:8'd17,  c:8'd5,   zero:8'd2,  g:8'd2,  z:8'd16,  eq:1'b1, div0:1'b0};
    tbl[1] = '{a:8'd17,  c:8'd5,   zero:8'd0,  g:8'd2,  z:8'd6,   eq:1'b0, div0:1'b0};
    tbl[2] = '{a:8'd0,   c:8'd1,   zero:8'd0,  g:8'd0,  z:8'd255, eq:1'b1, div0:1'b0};
    tbl[3] = '{a:8'd3,   c:8'd255, zero:8'd1,  g:8'd3,  z:8'd0,   eq:1'b0, div0:1'b0};
    tbl[4] = '{a:8'd9,   c:8'd0,   zero:8'd9,  g:8'd9,  z:8'd8,   eq:1'b1, div0:1'b1};
    tbl[5] = '{a:8'd200, c:8'd7,   zero:8'd4,  g:8'd4,  z:8'd199, eq:1'b1, div0:1'b0};
    tbl[6] = '{a:8'd255, c:8'd16,  zero:8'd15, g:8'd15, z:8'd254, eq:1'b1, div0:1'b0};
    tbl[7] = '{a:8'd100, c:8'd3,   zero:8'd0,  g:8'd1,  z:8'd4,   eq:1'b0, div0:1'b0};

    rst = 1'b1;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.c = '0; bus8.zero = '0; bus8.out_ready = 1'b0;
    bus64.in_valid = 1'b0; bus64.a = '0; bus64.c = '0; bus64.zero = '0; bus64.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus8.out_valid), 64'd0);
    chk("rst_z", 64'(bus8.z), 64'd0);
    chk("rst_g", 64'(bus8.g), 64'd0);
    chk("rst_eq", 64'(bus8.eq), 64'd0);
    chk("rst_div0", 64'(bus8.div0), 64'd0);
    chk("rst_in_ready", 64'(bus8.in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(bus8.in_ready), 64'd1);

    for (int i = 0; i < 8; i++) begin
      run8(tbl[i]);
      ack8();
    end

    // Backpressure with a second triple waiting during HOLD
    run8(tbl[0]);
    bus8.a = 8'd9; bus8.c = 8'd0; bus8.zero = 8'd9; bus8.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 64'(bus8.out_valid), 64'd1);
      chk("bp_z", 64'(bus8.z), 64'd16);
      chk("bp_g", 64'(bus8.g), 64'd2);
      chk("bp_eq", 64'(bus8.eq), 64'd1);
      chk("bp_div0", 64'(bus8.div0), 64'd0);
      chk("bp_in_ready", 64'(bus8.in_ready), 64'd0);
    end
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    chk("bp_release_out_valid", 64'(bus8.out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(bus8.in_ready), 64'd1);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    bus8.a = 8'hAA; bus8.c = 8'h55;
    chk("bp_second_accepted", 64'(bus8.in_ready), 64'd0);
    lat = 0;
    while (!bus8.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_second_latency", 64'(lat), 64'd9);
    chk("bp_second_g", 64'(bus8.g), 64'd9);
    chk("bp_second_z", 64'(bus8.z), 64'd8);
    chk("bp_second_eq", 64'(bus8.eq), 64'd1);
    chk("bp_second_div0", 64'(bus8.div0), 64'd1);
    ack8();

    // Reset in the middle of DIV
    bus8.a = 8'd200; bus8.c = 8'd7; bus8.zero = 8'd4; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(bus8.out_valid), 64'd0);
    chk("mid_rst_z", 64'(bus8.z), 64'd0);
    chk("mid_rst_g", 64'(bus8.g), 64'd0);
    chk("mid_rst_eq", 64'(bus8.eq), 64'd0);
    chk("mid_rst_div0", 64'(bus8.div0), 64'd0);
    chk("mid_rst_in_ready", 64'(bus8.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_in_ready", 64'(bus8.in_ready), 64'd1);
    chk("after_rst_out_valid", 64'(bus8.out_valid), 64'd0);
    v = tbl[0];
    run8(v);
    ack8();

    // Same case at DATAWIDTH = 64
    bus64.a = 64'd17; bus64.c = 64'd5; bus64.zero = 64'd2; bus64.in_valid = 1'b1;
    chk("w64_in_ready", 64'(bus64.in_ready), 64'd1);
    @(posedge clk); #1;
    bus64.in_valid = 1'b0;
    bus64.a = '1; bus64.c = '1;
    lat = 0;
    while (!bus64.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w64_latency", 64'(lat), 64'd65);
    chk("w64_g", bus64.g, 64'd2);
    chk("w64_z", bus64.z, 64'd16);
    chk("w64_eq", 64'(bus64.eq), 64'd1);
    chk("w64_div0", 64'(bus64.div0), 64'd0);
    bus64.out_ready = 1'b1;
    @(posedge clk); #1;
    bus64.out_ready = 1'b0;
    chk("w64_out_valid_after_ack", 64'(bus64.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
